hq_precoder_engine: RTL and testbench

Parametrised successor of the fixed 4x4-by-4x2 H·S_q engine. It buffers one channel matrix H (ROWS x INNER, complex fixed point) and computes Hq = H·S_q for every codebook entry q = 0..NUM_CB-1. Each S_q is INNER x COLS with entries restricted to {+0.5, -0.5, +0.5j, -0.5j}, so the datapath needs no multipliers. It sits between the channel-estimate stream and the precoder-selection metric block, with valid/ready handshakes on both sides.

---
 rtl/hq_pkg.sv | 48 ++++
 rtl/hq_precoder_engine_cmac.sv | 75 +++++++
 rtl/hq_precoder_engine.sv | 193 +++++++++++++++++++
 tb/tb_hq_precoder_engine.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hq_pkg.sv
// Shared definitions for the H*S_q precoder engine.
//   - cb_code encoding constants
//   - FSM state enum
//   - default 16 x 4 x 2 codebook table and a lookup helper used at reset
package hq_pkg;

    localparam logic [1:0] CB_POS  = 2'b00;  // +0.5
    localparam logic [1:0] CB_NEG  = 2'b01;  // -0.5
    localparam logic [1:0] CB_POSJ = 2'b10;  // +0.5j
    localparam logic [1:0] CB_NEGJ = 2'b11;  // -0.5j

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        OUT,
        DONE
    } state_t;

    localparam int unsigned DEF_NUM_CB = 16;
    localparam int unsigned DEF_INNER  = 4;
    localparam int unsigned DEF_COLS   = 2;

    // One 16-bit word per codebook entry q (q0 in the low word).
    // Within a word, entry (k, j) sits at bits [2*(k*2+j) +: 2].
    localparam logic [255:0] DEF_CB = {
        16'hC3C3, 16'hA5A5, 16'h6996, 16'h3C3C,
        16'hF0F0, 16'h0F0F, 16'hB1C6, 16'h2D78,
        16'hE41B, 16'h9C63, 16'h1234, 16'hFFFF,
        16'hAAAA, 16'h5555, 16'h0000, 16'h1010
    };

    // Reset code for entry (q, k, j); anything outside the 16 x 4 x 2 table is +0.5.
    function automatic logic [1:0] default_code(
        input int unsigned q,
        input int unsigned k,
        input int unsigned j,
        input int unsigned inner,
        input int unsigned cols
    );
        logic [255:0] tmp;
        if (inner != DEF_INNER || cols != DEF_COLS || q >= DEF_NUM_CB)
            return CB_POS;
        tmp = DEF_CB >> (16 * q + 2 * (k * DEF_COLS + j));
        return tmp[1:0];
    endfunction

endpackage

// File: rtl/hq_precoder_engine_cmac.sv
// hq_cmac_sel: complex sign/swap select and accumulator for one Hq element.
//   clk, rst        clock, asynchronous active-high reset (accumulator -> 0)
//   clear           first term of an element: load term instead of adding
//   en              accumulate this cycle
//   code            cb_code of the current S entry
//   h_r, h_i        current H element
//   res_r, res_i    (acc >>> 1) reduced to N bits
// Macro HQ_SAT_EN: defined -> saturate to N bits, undefined -> wrap.
module hq_cmac_sel #(
    parameter int unsigned N     = 16,
    parameter int unsigned INNER = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [1:0]   code,
    input  logic [N-1:0] h_r,
    input  logic [N-1:0] h_i,
    output logic [N-1:0] res_r,
    output logic [N-1:0] res_i
);
    import hq_pkg::*;

    localparam int unsigned AW = N + $clog2(INNER) + 1;

    logic signed [AW-1:0] ext_r, ext_i, term_r, term_i, acc_r, acc_i, sh_r, sh_i;

    assign ext_r = AW'($signed(h_r));
    assign ext_i = AW'($signed(h_i));

    // The 0.5 factor is applied once at the output shift, so terms are +-1, +-j.
    always_comb begin
        term_r = ext_r;
        term_i = ext_i;
        case (code)
            CB_NEG:  begin term_r = -ext_r; term_i = -ext_i; end
            CB_POSJ: begin term_r = -ext_i; term_i =  ext_r; end
            CB_NEGJ: begin term_r =  ext_i; term_i = -ext_r; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
            acc_i <= '0;
        end else if (en) begin
            acc_r <= clear ? term_r : acc_r + term_r;
            acc_i <= clear ? term_i : acc_i + term_i;
        end
    end

    assign sh_r = acc_r >>> 1;
    assign sh_i = acc_i >>> 1;

`ifdef HQ_SAT_EN
    localparam logic signed [AW-1:0] MAXV = {{(AW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-N+1){1'b1}}, {(N-1){1'b0}}};

    function automatic logic [N-1:0] reduce(input logic signed [AW-1:0] v);
        if (v > MAXV) return MAXV[N-1:0];
        if (v < MINV) return MINV[N-1:0];
        return v[N-1:0];
    endfunction
`else
    function automatic logic [N-1:0] reduce(input logic signed [AW-1:0] v);
        return v[N-1:0];
    endfunction
`endif

    assign res_r = reduce(sh_r);
    assign res_i = reduce(sh_i);

endmodule

// File: rtl/hq_precoder_engine.sv
// hq_precoder_engine: buffers H (ROWS x INNER) and streams Hq = H*S_q for all
// NUM_CB codebook entries, one element per handshake (j fastest, then row, then q).
//   clk, rst                   clock, asynchronous active-high reset
//   start                      begin a run (IDLE only)
//   h_valid/h_ready, h_r/h_i   H input stream, row-major
//   cb_we/cb_addr/cb_code      codebook write (IDLE only), addr = q*INNER*COLS + k*COLS + j
//   out_valid/out_ready        Hq output handshake
//   out_r/out_i                Hq element
//   out_q/out_row/out_col      element tags
//   mat_done                   last element of the current Hq
//   all_done                   one-cycle pulse after the final handshake
//   busy                       not IDLE
// Macro HQ_SAT_EN selects saturating (defined) or wrapping (undefined) output.
module hq_precoder_engine #(
    parameter int unsigned N      = 16,
    parameter int unsigned FRAC   = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned INNER  = 4,
    parameter int unsigned COLS   = 2,
    parameter int unsigned NUM_CB = 16,
    localparam int unsigned CB_DEPTH = NUM_CB * INNER * COLS,
    localparam int unsigned CBW = (CB_DEPTH > 1) ? $clog2(CB_DEPTH) : 1,
    localparam int unsigned QW  = (NUM_CB > 1) ? $clog2(NUM_CB) : 1,
    localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           h_valid,
    output logic           h_ready,
    input  logic [N-1:0]   h_r,
    input  logic [N-1:0]   h_i,
    input  logic           cb_we,
    input  logic [CBW-1:0] cb_addr,
    input  logic [1:0]     cb_code,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_r,
    output logic [N-1:0]   out_i,
    output logic [QW-1:0]  out_q,
    output logic [RW-1:0]  out_row,
    output logic [CW-1:0]  out_col,
    output logic           mat_done,
    output logic           all_done,
    output logic           busy
);
    import hq_pkg::*;

    localparam int unsigned HD = ROWS * INNER;
    localparam int unsigned HW = (HD > 1) ? $clog2(HD) : 1;
    localparam int unsigned KW = (INNER > 1) ? $clog2(INNER) : 1;

    state_t state, state_nxt;

    logic [HW-1:0]  ld_cnt;
    logic [QW-1:0]  q_cnt;
    logic [RW-1:0]  i_cnt;
    logic [CW-1:0]  j_cnt;
    logic [KW-1:0]  k_cnt;
    logic [N-1:0]   hmem_r [HD];
    logic [N-1:0]   hmem_i [HD];
    logic [1:0]     cb_mem [CB_DEPTH];
    logic           ld_last, k_last, j_last, i_last, q_last;
    logic [HW-1:0]  h_idx;
    logic [CBW-1:0] cb_idx;
    logic           acc_clr, acc_en;

    assign ld_last = (ld_cnt == HW'(HD - 1));
    assign k_last  = (k_cnt == KW'(INNER - 1));
    assign j_last  = (j_cnt == CW'(COLS - 1));
    assign i_last  = (i_cnt == RW'(ROWS - 1));
    assign q_last  = (q_cnt == QW'(NUM_CB - 1));

    assign h_idx  = HW'(32'(i_cnt) * INNER + 32'(k_cnt));
    assign cb_idx = CBW'(32'(q_cnt) * (INNER * COLS) + 32'(k_cnt) * COLS + 32'(j_cnt));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)             state_nxt = LOAD;
            LOAD: if (h_valid && ld_last) state_nxt = CALC;
            CALC: if (k_last)            state_nxt = OUT;
            OUT:  if (out_ready)         state_nxt = (q_last && i_last && j_last) ? DONE : CALC;
            DONE:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        h_ready   = 1'b0;
        out_valid = 1'b0;
        mat_done  = 1'b0;
        all_done  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: busy = 1'b0;
            LOAD: h_ready = 1'b1;
            OUT: begin
                out_valid = 1'b1;
                mat_done  = i_last && j_last;
            end
            DONE: all_done = 1'b1;
            default: ;
        endcase
    end

    // Load / element / term counters; none move while OUT waits on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
            q_cnt  <= '0;
            i_cnt  <= '0;
            j_cnt  <= '0;
            k_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ld_cnt <= '0;
                    q_cnt  <= '0;
                    i_cnt  <= '0;
                    j_cnt  <= '0;
                    k_cnt  <= '0;
                end
                LOAD: if (h_valid) ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
                CALC: k_cnt <= k_last ? '0 : k_cnt + 1'b1;
                OUT: if (out_ready) begin
                    if (j_last) begin
                        j_cnt <= '0;
                        if (i_last) begin
                            i_cnt <= '0;
                            q_cnt <= q_last ? '0 : q_cnt + 1'b1;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // H buffer carries no reset; its contents are only read after a full LOAD.
    always_ff @(posedge clk) begin
        if (state == LOAD && h_valid) begin
            hmem_r[ld_cnt] <= h_r;
            hmem_i[ld_cnt] <= h_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned a = 0; a < CB_DEPTH; a++)
                cb_mem[CBW'(a)] <= default_code(a / (INNER * COLS), (a / COLS) % INNER,
                                                a % COLS, INNER, COLS);
        end else if (cb_we && state == IDLE && 32'(cb_addr) < CB_DEPTH) begin
            cb_mem[cb_addr] <= cb_code;
        end
    end

    assign acc_en  = (state == CALC);
    assign acc_clr = (state == CALC) && (k_cnt == '0);

    hq_cmac_sel #(
        .N     (N),
        .INNER (INNER)
    ) u_cmac (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clr),
        .en    (acc_en),
        .code  (cb_mem[cb_idx]),
        .h_r   (hmem_r[h_idx]),
        .h_i   (hmem_i[h_idx]),
        .res_r (out_r),
        .res_i (out_i)
    );

    assign out_q   = q_cnt;
    assign out_row = i_cnt;
    assign out_col = j_cnt;

endmodule

// File: tb/tb_hq_precoder_engine.sv
// Bench for hq_precoder_engine: complex-arithmetic reference model with an
// expected-element queue, one negedge compare process, plus literal checks.
module tb_hq_precoder_engine;

    localparam int N      = 16;
    localparam int ROWS   = 4;
    localparam int INNER  = 4;
    localparam int COLS   = 2;
    localparam int NUM_CB = 16;
    localparam int NEL    = NUM_CB * ROWS * COLS;
    localparam int CBD    = NUM_CB * INNER * COLS;

    logic          clk = 1'b0;
    logic          rst, start, h_valid, cb_we, out_ready;
    logic          h_ready, out_valid, mat_done, all_done, busy;
    logic [N-1:0]  h_r, h_i, out_r, out_i;
    logic [6:0]    cb_addr;
    logic [1:0]    cb_code;
    logic [3:0]    out_q;
    logic [1:0]    out_row;
    logic [0:0]    out_col;

    hq_precoder_engine #(
        .N(N), .FRAC(8), .ROWS(ROWS), .INNER(INNER), .COLS(COLS), .NUM_CB(NUM_CB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .h_valid(h_valid), .h_ready(h_ready), .h_r(h_r), .h_i(h_i),
        .cb_we(cb_we), .cb_addr(cb_addr), .cb_code(cb_code),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_i(out_i),
        .out_q(out_q), .out_row(out_row), .out_col(out_col),
        .mat_done(mat_done), .all_done(all_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int i;
        int q;
        int row;
        int col;
        int md;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   hr [ROWS][INNER];
    int   hi [ROWS][INNER];
    int   cbm [CBD];
    exp_t expq [$];
    int   n_out, done_cnt, cap_n;
    int   cap_r [8];
    int   cap_i [8];
    int   cap_md [8];
    bit   done_due = 1'b0;
    bit   chk_on = 1'b0;

    // Default codebook, one word per q, entry (k,j) at bits [2*(k*2+j) +: 2].
    logic [15:0] ref_cb [NUM_CB] = '{
        16'h1010, 16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h1234, 16'h9C63, 16'hE41B,
        16'h2D78, 16'hB1C6, 16'h0F0F, 16'hF0F0, 16'h3C3C, 16'h6996, 16'hA5A5, 16'hC3C3
    };

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic void load_default_cb();
        for (int a = 0; a < CBD; a++) begin
            logic [15:0] w;
            w = ref_cb[a / (INNER * COLS)] >> (2 * (a % (INNER * COLS)));
            cbm[a] = int'(w[1:0]);
        end
    endfunction

    function automatic int reduce(input int v);
`ifdef HQ_SAT_EN
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        int w;
        w = v & 32'hFFFF;
        if (w > 32767) w -= 65536;
        return w;
`endif
    endfunction

    // Hq[i][j] = sum_k H[i][k] * u_k, with u in {+1,-1,+j,-j}, then halved (floor).
    function automatic exp_t model(input int q, input int i, input int j);
        exp_t e;
        int ar, ai, ur, ui;
        ar = 0;
        ai = 0;
        for (int k = 0; k < INNER; k++) begin
            case (cbm[q * INNER * COLS + k * COLS + j])
                0:       begin ur =  1; ui =  0; end
                1:       begin ur = -1; ui =  0; end
                2:       begin ur =  0; ui =  1; end
                default: begin ur =  0; ui = -1; end
            endcase
            ar += ur * hr[i][k] - ui * hi[i][k];
            ai += ur * hi[i][k] + ui * hr[i][k];
        end
        e.r   = reduce(ar >>> 1);
        e.i   = reduce(ai >>> 1);
        e.q   = q;
        e.row = i;
        e.col = j;
        e.md  = (i == ROWS - 1 && j == COLS - 1) ? 1 : 0;
        return e;
    endfunction

    // Single compare process for everything observable on the output side.
    always @(negedge clk) begin
        if (!rst && chk_on) begin
            check("all_done", int'(all_done), int'(done_due));
            done_due = 1'b0;
            if (all_done) done_cnt++;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    check("spurious_out_valid", int'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = expq[0];
                    check("out_r",    int'($signed(out_r)), e.r);
                    check("out_i",    int'($signed(out_i)), e.i);
                    check("out_q",    int'(out_q),   e.q);
                    check("out_row",  int'(out_row), e.row);
                    check("out_col",  int'(out_col), e.col);
                    check("mat_done", int'(mat_done), e.md);
                    if (out_ready) begin
                        if (cap_n < 8) begin
                            cap_r[cap_n]  = int'($signed(out_r));
                            cap_i[cap_n]  = int'($signed(out_i));
                            cap_md[cap_n] = int'(mat_done);
                        end
                        cap_n++;
                        void'(expq.pop_front());
                        n_out++;
                        if (expq.size() == 0) done_due = 1'b1;
                    end
                end
            end else begin
                check("mat_done_without_valid", int'(mat_done), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cb(input int a, input int c);
        cb_we   = 1'b1;
        cb_addr = 7'(a);
        cb_code = 2'(c);
        tick();
        cb_we = 1'b0;
        cbm[a] = c;
    endtask

    task automatic set_h_identity();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < INNER; c++) begin
                hr[r][c] = (r == c) ? 256 : 0;
                hi[r][c] = 0;
            end
    endtask

    task automatic set_h_random();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < INNER; c++) begin
                hr[r][c] = int'($urandom_range(0, 65535)) - 32768;
                hi[r][c] = int'($urandom_range(0, 65535)) - 32768;
            end
    endtask

    task automatic start_run();
        n_out    = 0;
        done_cnt = 0;
        cap_n    = 0;
        for (int q = 0; q < NUM_CB; q++)
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++)
                    expq.push_back(model(q, i, j));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("h_ready_in_load", int'(h_ready), 1);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < INNER; c++) begin
                while ($urandom_range(0, 3) == 0) tick();
                h_valid = 1'b1;
                h_r     = N'(hr[r][c]);
                h_i     = N'(hi[r][c]);
                tick();
                h_valid = 1'b0;
            end
    endtask

    // mode 0: ready high; 1: random ready; 2: 5-cycle stall on 3rd element;
    // 3: random ready plus start/cb_we/h_valid pokes while busy.
    task automatic drain(input int mode);
        int cyc, bp;
        cyc = 0;
        bp  = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            start   = 1'b0;
            cb_we   = 1'b0;
            h_valid = 1'b0;
            case (mode)
                0: out_ready = 1'b1;
                2: begin
                    if (out_valid && n_out == 2 && bp < 5) begin
                        out_ready = 1'b0;
                        bp++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (mode == 3 && busy && $urandom_range(0, 3) == 0) begin
                start   = 1'b1;
                cb_we   = 1'b1;
                cb_addr = 7'($urandom_range(0, CBD - 1));
                cb_code = 2'($urandom_range(0, 3));
                h_valid = 1'b1;
                h_r     = 16'($urandom);
                h_i     = 16'($urandom);
            end
            tick();
            cyc++;
        end
        start     = 1'b0;
        cb_we     = 1'b0;
        h_valid   = 1'b0;
        out_ready = 1'b1;
        if (done_cnt == 0) check("run_timeout_cycles", cyc, -1);
        if (mode == 2) check("stall_cycles", bp, 5);
        tick();
        tick();
        check("n_out", n_out, NEL);
        check("all_done_pulses", done_cnt, 1);
        check("busy_after_done", int'(busy), 0);
        check("expected_left", expq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_h_ready"},   int'(h_ready),   0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_mat_done"},  int'(mat_done),  0);
        check({tag, "_all_done"},  int'(all_done),  0);
        check({tag, "_busy"},      int'(busy),      0);
        check({tag, "_out_r"},     int'(out_r),     0);
        check({tag, "_out_i"},     int'(out_i),     0);
        check({tag, "_out_q"},     int'(out_q),     0);
        check({tag, "_out_row"},   int'(out_row),   0);
        check({tag, "_out_col"},   int'(out_col),   0);
    endtask

    // q0 identity: order (r0c0, r0c1, r1c0, r1c1, ...): col0 alternates +/-, col1 all +.
    task automatic check_identity_caps();
        int lit_r [8];
        lit_r = '{128, 128, -128, 128, 128, 128, -128, 128};
        for (int n = 0; n < 8; n++) begin
            check($sformatf("ident_r_%0d", n), cap_r[n], lit_r[n]);
            check($sformatf("ident_i_%0d", n), cap_i[n], 0);
            check($sformatf("ident_md_%0d", n), cap_md[n], (n == 7) ? 1 : 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        h_valid   = 1'b0;
        h_r       = '0;
        h_i       = '0;
        cb_we     = 1'b0;
        cb_addr   = '0;
        cb_code   = '0;
        out_ready = 1'b1;
        load_default_cb();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk_on = 1'b1;

        // Identity H with the default codebook
        set_h_identity();
        start_run();
        drain(0);
        check_identity_caps();

        // Codebook write: entry (q0,k0,j0) -> +j
        write_cb(0, 2);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < INNER; c++) begin
                hr[r][c] = 0;
                hi[r][c] = 0;
            end
        hr[0][0] = 256;
        start_run();
        drain(1);
        check("cbw_el0_r", cap_r[0], 0);
        check("cbw_el0_i", cap_i[0], 128);

        // Overflow: all codes +0.5, H all 0x7FFF real
        for (int a = 0; a < CBD; a++) write_cb(a, 0);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < INNER; c++) begin
                hr[r][c] = 32767;
                hi[r][c] = 0;
            end
        start_run();
        drain(0);
`ifdef HQ_SAT_EN
        check("ovf_el0_r", cap_r[0], 32767);
`else
        check("ovf_el0_r", cap_r[0], -2);
`endif

        // Backpressure on the 3rd element
        set_h_random();
        start_run();
        drain(2);

        // Start / cb_we / h_valid while busy must all be ignored
        set_h_random();
        start_run();
        drain(3);

        // Reset during CALC of q = 5
        set_h_random();
        start_run();
        begin
            int cyc;
            cyc = 0;
            out_ready = 1'b1;
            while (n_out < 40 && cyc < 2000) begin
                tick();
                cyc++;
            end
            if (n_out < 40) check("midrun_timeout_cycles", cyc, -1);
        end
        tick();
        tick();
        check("q_before_reset", int'(out_q), 5);
        check("valid_before_reset", int'(out_valid), 0);
        rst = 1'b1;
        #1;
        expq.delete();
        done_due = 1'b0;
        check_reset_outputs("midrun");
        tick();
        rst = 1'b0;
        load_default_cb();
        tick();

        // Default codebook must be back: identity run again
        set_h_identity();
        start_run();
        drain(0);
        check_identity_caps();

        set_h_random();
        start_run();
        drain(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
